// File: rtl/rx_rr_arbiter_if.sv
// Purpose: rx-port / input-FIFO bundle between the rx deserialisers and rx_rr_arbiter.
// Latency: none (signal bundle only).
// Backpressure: full from the FIFO side stalls the arbiter stage; item_read pops rx ports.
//   valid     rx port i holds a complete item (DIRS bits)
//   items     flattened rx items, port i at [i*ITEM_W +: ITEM_W]
//   item_read one-hot pop strobe back to the rx ports
//   full      FIFO full
//   item_out  staged item to the FIFO item_in
//   write     FIFO write strobe
// Modports: slave = arbiter view, master = rx ports + FIFO view.
interface rx_rr_arbiter_if #(
    parameter int DIRS   = 5,
    parameter int ITEM_W = 16
) ();
    logic [DIRS-1:0]        valid;
    logic [DIRS*ITEM_W-1:0] items;
    logic [DIRS-1:0]        item_read;
    logic                   full;
    logic [ITEM_W-1:0]      item_out;
    logic                   write;

    modport slave (
        input  valid, items, full,
        output item_read, item_out, write
    );

    modport master (
        output valid, items, full,
        input  item_read, item_out, write
    );
endinterface

// File: rtl/rx_rr_arbiter.sv
// Purpose: round-robin arbiter from DIRS rx deserialisers (0=N,1=E,2=S,3=W,4=L) into the shared input FIFO.
// Latency: one registered stage; an item read this cycle is written to the FIFO next cycle if not full.
// Backpressure: while full holds the stage, no grants occur and item_out stays stable; 1 item/cycle otherwise.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; discards any staged item
//   bus        rx_rr_arbiter_if.slave (valid, items, item_read, full, item_out, write)
//   grant_cnt  DIRS x 16-bit saturating per-port grant counters (only when ARB_STATS_EN is defined)
// Optional feature macro: ARB_STATS_EN
module rx_rr_arbiter #(
    parameter int DIRS   = 5,
    parameter int ITEM_W = 16
) (
    input  logic               clk,
    input  logic               reset,
`ifdef ARB_STATS_EN
    output logic [DIRS*16-1:0] grant_cnt,
`endif
    rx_rr_arbiter_if.slave     bus
);
    localparam int PTR_W = (DIRS > 1) ? $clog2(DIRS) : 1;

    // ptr holds the last granted port; search starts just after it.
    logic [PTR_W-1:0]  ptr;
    logic              out_valid;
    logic [ITEM_W-1:0] out_item;

    logic              gnt_found;
    logic [PTR_W-1:0]  gnt_idx;
    logic [DIRS-1:0]   gnt_oh;
    logic [ITEM_W-1:0] gnt_item;
    logic              slot_free;
    logic              do_grant;

    // Rotating priority scan: ptr+1, ptr+2, ... wrapping at DIRS; the
    // first requester seen wins. Scanning offsets 1..DIRS makes the last
    // granted port the lowest priority, which is what prevents starvation.
    always_comb begin
        int cand;
        cand      = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_oh    = '0;
        gnt_item  = '0;
        for (int k = 1; k <= DIRS; k++) begin
            cand = (int'(ptr) + k) % DIRS;
            if (!gnt_found && bus.valid[cand]) begin
                gnt_found    = 1'b1;
                gnt_idx      = PTR_W'(cand);
                gnt_oh[cand] = 1'b1;
                gnt_item     = bus.items[cand*ITEM_W +: ITEM_W];
            end
        end
    end

    // The stage can accept a new item if empty or emptying this cycle,
    // so a write and a grant can overlap for full throughput.
    assign bus.write     = out_valid & ~bus.full;
    assign slot_free     = ~out_valid | bus.write;
    assign do_grant      = slot_free & gnt_found;
    assign bus.item_read = do_grant ? gnt_oh : '0;
    assign bus.item_out  = out_item;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= PTR_W'(DIRS - 1);
            out_valid <= 1'b0;
            out_item  <= '0;
        end else if (do_grant) begin
            // items[g] is captured here; the rx port moves on next cycle.
            ptr       <= gnt_idx;
            out_valid <= 1'b1;
            out_item  <= gnt_item;
        end else if (bus.write) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] cnt [DIRS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DIRS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < DIRS; i++) begin
                if (bus.item_read[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

    for (genvar gi = 0; gi < DIRS; gi++) begin : g_cnt_out
        assign grant_cnt[gi*16 +: 16] = cnt[gi];
    end
`endif

    a_read_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(bus.item_read));
    a_read_needs_slot: assert property (@(posedge clk) disable iff (reset) (|bus.item_read) |-> slot_free);
endmodule

// File: tb/tb_rx_rr_arbiter.sv
module tb_rx_rr_arbiter;
    localparam int DIRS   = 5;
    localparam int ITEM_W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rx_rr_arbiter_if #(.DIRS(DIRS), .ITEM_W(ITEM_W)) bus ();
`ifdef ARB_STATS_EN
    logic [DIRS*16-1:0] grant_cnt;
`endif

    rx_rr_arbiter #(.DIRS(DIRS), .ITEM_W(ITEM_W)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef ARB_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .bus       (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: items expected on item_out, pushed when a grant is predicted.
    logic [ITEM_W-1:0] sb_q[$];
    int                m_ptr  = DIRS - 1;
    bit                m_ovld = 1'b0;
    int                n_writes = 0;
    logic [DIRS-1:0]   last_rd = '0;

    function automatic logic [DIRS*ITEM_W-1:0] rand_items();
        logic [DIRS*ITEM_W-1:0] r;
        for (int i = 0; i < DIRS; i++) r[i*ITEM_W +: ITEM_W] = ITEM_W'($urandom);
        return r;
    endfunction

    // One clock cycle: drive at negedge, check combinational outputs 1ns later
    // against the reference model, then advance the model to post-edge state.
    task automatic cycle(input logic [DIRS-1:0] v, input logic f, input logic [DIRS*ITEM_W-1:0] it);
        logic [DIRS-1:0]   exp_rd;
        logic [ITEM_W-1:0] exp_item;
        bit                exp_wr;
        bit                free;
        int                g;
        int                j;
        @(negedge clk);
        bus.valid = v;
        bus.full  = f;
        bus.items = it;
        #1;
        exp_wr = m_ovld && !f;
        free   = !m_ovld || exp_wr;
        exp_rd = '0;
        g      = -1;
        j      = 0;
        if (free) begin
            while (j < DIRS && g < 0) begin
                j++;
                if (v[(m_ptr + j) % DIRS]) g = (m_ptr + j) % DIRS;
            end
        end
        if (g >= 0) exp_rd[g] = 1'b1;
        n_tests++;
        if (bus.item_read !== exp_rd) begin
            n_fail++;
            $display("FAIL model_item_read: got %b expected %b", bus.item_read, exp_rd);
        end
        n_tests++;
        if (bus.write !== exp_wr) begin
            n_fail++;
            $display("FAIL model_write: got %b expected %b", bus.write, exp_wr);
        end
        if (exp_wr) begin
            n_writes++;
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: write seen with no expected item");
            end else begin
                exp_item = sb_q.pop_front();
                if (bus.item_out !== exp_item) begin
                    n_fail++;
                    $display("FAIL item_out: got %h expected %h", bus.item_out, exp_item);
                end
            end
        end
        if (g >= 0) begin
            sb_q.push_back(it[g*ITEM_W +: ITEM_W]);
            m_ptr  = g;
            m_ovld = 1'b1;
        end else if (exp_wr) begin
            m_ovld = 1'b0;
        end
        last_rd = bus.item_read;
    endtask

    task automatic model_reset();
        m_ptr  = DIRS - 1;
        m_ovld = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b expected 0", bus.write); end
        n_tests++;
        if (bus.item_out !== '0) begin n_fail++; $display("FAIL reset_item_out: got %h expected 0", bus.item_out); end
        n_tests++;
        if (bus.item_read !== '0) begin n_fail++; $display("FAIL reset_item_read: got %b expected 0", bus.item_read); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_rr_all();
        logic [DIRS-1:0] exp;
        for (int c = 0; c < 10; c++) begin
            cycle(5'b11111, 1'b0, rand_items());
            exp = '0;
            exp[c % DIRS] = 1'b1;
            n_tests++;
            if (bus.item_read !== exp) begin
                n_fail++;
                $display("FAIL rr_all_seq c=%0d: got %b expected %b", c, bus.item_read, exp);
            end
            n_tests++;
            if (bus.write !== (c > 0)) begin
                n_fail++;
                $display("FAIL rr_all_write c=%0d: got %b expected %b", c, bus.write, (c > 0));
            end
        end
    endtask

    task automatic test_two_ports();
        logic [DIRS-1:0] prev;
        for (int c = 0; c < 8; c++) begin
            prev = last_rd;
            cycle(5'b10001, 1'b0, rand_items());
            n_tests++;
            if (!((bus.item_read === 5'b00001 && prev !== 5'b00001) ||
                  (bus.item_read === 5'b10000 && prev !== 5'b10000))) begin
                n_fail++;
                $display("FAIL two_ports_alt c=%0d: got %b after %b", c, bus.item_read, prev);
            end
        end
    endtask

    task automatic test_full_hold();
        logic [DIRS*ITEM_W-1:0] it;
        it = rand_items();
        it[2*ITEM_W +: ITEM_W] = 16'h00AB;
        cycle(5'b00100, 1'b0, it);
        for (int c = 0; c < 4; c++) begin
            cycle(5'b00100, 1'b1, rand_items());
            n_tests++;
            if (bus.write !== 1'b0 || bus.item_read !== '0 || bus.item_out !== 16'h00AB) begin
                n_fail++;
                $display("FAIL full_hold c=%0d: got write=%b read=%b out=%h expected 0 00000 00ab",
                         c, bus.write, bus.item_read, bus.item_out);
            end
        end
        cycle(5'b00100, 1'b0, rand_items());
        n_tests++;
        if (bus.write !== 1'b1 || bus.item_read !== 5'b00100) begin
            n_fail++;
            $display("FAIL full_release: got write=%b read=%b expected 1 00100", bus.write, bus.item_read);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.valid = '0;
        bus.full  = 1'b0;
        reset     = 1'b1;
        #1;
        n_tests++;
        if (bus.write !== 1'b0 || bus.item_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got write=%b out=%h expected 0 0000", bus.write, bus.item_out);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cycle(5'b01010, 1'b0, rand_items());
        n_tests++;
        if (bus.item_read !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_mid_grant: got %b expected 00010", bus.item_read);
        end
    endtask

    task automatic test_idle_drain();
        cycle(5'b00001, 1'b0, rand_items());
        n_writes = 0;
        for (int c = 0; c < 10; c++) cycle(5'b00000, 1'b0, rand_items());
        n_tests++;
        if (n_writes != 1) begin
            n_fail++;
            $display("FAIL idle_drain_writes: got %0d expected 1", n_writes);
        end
        cycle(5'b11111, 1'b0, rand_items());
        n_tests++;
        if (bus.item_read !== 5'b00010) begin
            n_fail++;
            $display("FAIL idle_ptr_kept: got %b expected 00010", bus.item_read);
        end
    endtask

    task automatic test_single();
        for (int c = 0; c < 6; c++) begin
            cycle(5'b01000, 1'b0, rand_items());
            n_tests++;
            if (bus.item_read !== 5'b01000) begin
                n_fail++;
                $display("FAIL single_req c=%0d: got %b expected 01000", c, bus.item_read);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++)
            cycle(DIRS'($urandom), ($urandom_range(0, 3) == 0), rand_items());
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        reset = 1'b1;
        bus.valid = '0;
        bus.full  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bus.valid = 5'b00010;
        repeat (70000) @(negedge clk);
        for (int i = 0; i < DIRS; i++) begin
            n_tests++;
            if (grant_cnt[i*16 +: 16] !== ((i == 1) ? 16'hFFFF : 16'h0000)) begin
                n_fail++;
                $display("FAIL stats_cnt%0d: got %h expected %h", i, grant_cnt[i*16 +: 16],
                         ((i == 1) ? 16'hFFFF : 16'h0000));
            end
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        bus.valid = '0;
        bus.full  = 1'b0;
        bus.items = '0;
        test_reset();
        test_rr_all();
        test_two_ports();
        test_full_hold();
        test_reset_mid();
        test_idle_drain();
        test_single();
        test_random();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
